// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle multiply/divide engine for the execute stage. Owns the
//   architectural HI/LO registers, runs MULT/MULTU/DIV/DIVU over 32
//   iterations, and services MTHI/MTLO writes in a single cycle.
//
// Ports
//   clk         clock, rising-edge
//   resetn      asynchronous active-low reset
//   start       operation request
//   alucontrol  8-bit EXE_*_OP code
//   a, b        rs / rt operands
//   annul       flush; aborts an in-flight op or suppresses a request
//   busy        engine occupied (registered), pipeline must stall
//   done        one-cycle pulse, hi/lo hold the new result
//   hi, lo      architectural HI / LO
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; MTHI/MTLO are written here
// MUL   | shift-add multiply, one multiplier bit per edge
// DIV   | restoring divide, one quotient bit per edge
// FIN   | sign fix-up and HI/LO write (skipped write for zero divisor)

module hilo_muldiv_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [7:0]    alucontrol,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          annul,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state;
  logic [4:0]       counter;
  // MUL: {partial product, remaining multiplier bits}
  // DIV: {partial remainder, dividend bits shifting into quotient}
  logic [2*DW-1:0]  acc;
  logic [DW-1:0]    opb;      // multiplicand or divisor magnitude
  logic             neg_q;    // negate product / quotient
  logic             neg_r;    // negate remainder
  logic             op_div;
  logic             skip_wr;  // zero divisor: leave HI/LO untouched

  logic             is_mul, is_div, is_signed;
  logic [DW-1:0]    a_mag, b_mag;

  always_comb begin
    is_mul    = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_MULTU_OP);
    is_div    = (alucontrol == EXE_DIV_OP)  || (alucontrol == EXE_DIVU_OP);
    is_signed = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_DIV_OP);
    a_mag     = (is_signed && a[DW-1]) ? -a : a;
    b_mag     = (is_signed && b[DW-1]) ? -b : b;
  end

  logic [DW:0]     mul_sum;
  logic [DW:0]     div_shift;
  logic            div_fits;
  logic [DW-1:0]   div_rem;
  logic [2*DW-1:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*DW-1:DW]} + {1'b0, (acc[0] ? opb : {DW{1'b0}})};
    div_shift = {acc[2*DW-1:DW], acc[DW-1]};
    div_fits  = (div_shift >= {1'b0, opb});
    // When the divisor fits the difference is below the divisor, so the
    // low DW bits of the subtraction are exact.
    div_rem   = div_fits ? (div_shift[DW-1:0] - opb) : div_shift[DW-1:0];
    if (state == DIV) acc_next = {div_rem, acc[DW-2:0], div_fits};
    else              acc_next = {mul_sum, acc[DW-1:1]};
  end

  logic [2*DW-1:0] prod_res;
  logic [DW-1:0]   quot_res, rem_res;

  always_comb begin
    prod_res = neg_q ? -acc : acc;
    quot_res = neg_q ? -acc[DW-1:0] : acc[DW-1:0];
    rem_res  = neg_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      counter <= '0;
      acc     <= '0;
      opb     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      op_div  <= 1'b0;
      skip_wr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            if (is_mul || is_div) begin
              neg_q   <= is_signed && (a[DW-1] ^ b[DW-1]);
              neg_r   <= is_signed && a[DW-1];
              op_div  <= is_div;
              busy    <= 1'b1;
              counter <= 5'd31;
              if (is_mul) begin
                acc     <= {{DW{1'b0}}, b_mag};
                opb     <= a_mag;
                skip_wr <= 1'b0;
                state   <= MUL;
              end else if (b == '0) begin
                skip_wr <= 1'b1;
                state   <= FIN;
              end else begin
                acc     <= {{DW{1'b0}}, a_mag};
                opb     <= b_mag;
                skip_wr <= 1'b0;
                state   <= DIV;
              end
            end else if (alucontrol == EXE_MTHI_OP) begin
              hi <= a;
            end else if (alucontrol == EXE_MTLO_OP) begin
              lo <= a;
            end
          end
        end
        MUL, DIV: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc     <= acc_next;
            counter <= counter - 5'd1;
            if (counter == 5'd0) state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!annul) begin
            done <= 1'b1;
            if (!skip_wr) begin
              if (op_div) begin
                hi <= rem_res;
                lo <= quot_res;
              end else begin
                hi <= prod_res[2*DW-1:DW];
                lo <= prod_res[DW-1:0];
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  alucontrol;
  logic [31:0] a, b;
  logic        annul;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] v;
  } exp_t;
  exp_t exp_q[$];

  hilo_muldiv_unit #(.DW(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .alucontrol(alucontrol),
    .a(a), .b(b), .annul(annul), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (resetn && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e.v) begin
          errors++;
          $display("FAIL %s got hi=%h lo=%h want hi=%h lo=%h",
                   e.name, hi, lo, e.v[63:32], e.v[31:0]);
        end
      end
    end
    if (resetn && busy && done) begin
      errors++;
      $display("FAIL busy_and_done both high at %0t", $time);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_res(input string nm, input logic [63:0] v);
    exp_t e;
    e.name = nm;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; holds the request across one rising edge.
  task automatic issue(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv);
    start      = 1'b1;
    alucontrol = op;
    a          = av;
    b          = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done shows; returns at the done falling edge.
  task automatic wait_done(input string nm, input int exp_busy);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout no done within 100 cycles", nm);
    end else if (exp_busy >= 0 && nb != exp_busy) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d want %0d", nm, nb, exp_busy);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; alucontrol = 8'h00;
    a = '0; b = '0; annul = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // -3 * 5 = -15
    expect_res("mult_neg3x5", 64'hFFFFFFFF_FFFFFFF1);
    issue(EXE_MULT_OP, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_neg3x5", 33);
    @(negedge clk);

    // MULTU max*max, then DIVU started in the done cycle
    expect_res("multu_max", 64'hFFFFFFFE_00000001);
    issue(EXE_MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 33);
    expect_res("divu_100_7", {32'd2, 32'd14});
    issue(EXE_DIVU_OP, 32'd100, 32'd7);
    wait_done("divu_100_7", 33);
    @(negedge clk);

    expect_res("div_neg7_2", 64'hFFFFFFFF_FFFFFFFD);
    issue(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg7_2", 33);
    @(negedge clk);

    expect_res("div_minint_neg1", 64'h00000000_80000000);
    issue(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_minint_neg1", 33);
    @(negedge clk);

    // MTHI / MTLO presets
    issue(EXE_MTHI_OP, 32'h11, 32'h0);
    chk("mthi_visible", {32'd0, hi}, 64'h11);
    chk("mthi_no_busy_done", {62'd0, busy, done}, 64'd0);
    issue(EXE_MTLO_OP, 32'h22, 32'h0);
    chk("mtlo_visible", {hi, lo}, {32'h11, 32'h22});
    chk("mtlo_no_busy_done", {62'd0, busy, done}, 64'd0);

    // zero divisor: one busy cycle, HI/LO untouched
    expect_res("divu_by_zero", {32'h11, 32'h22});
    issue(EXE_DIVU_OP, 32'd5, 32'd0);
    wait_done("divu_by_zero", 1);
    @(negedge clk);

    // annul mid-MULT
    issue(EXE_MULT_OP, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_idle_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("annul_hilo_kept", {hi, lo}, {32'h11, 32'h22});

    // annul together with MTLO suppresses the write
    annul = 1'b1;
    issue(EXE_MTLO_OP, 32'h99, 32'h0);
    annul = 1'b0;
    chk("annul_mtlo_suppressed", {hi, lo}, {32'h11, 32'h22});

    // unrecognised / read-only codes do nothing
    issue(EXE_MFHI_OP, 32'h5, 32'h6);
    chk("mfhi_ignored_busy", {63'd0, busy}, 64'd0);
    issue(EXE_ADD_OP, 32'h5, 32'h6);
    chk("add_ignored_busy", {63'd0, busy}, 64'd0);
    chk("ignored_hilo_kept", {hi, lo}, {32'h11, 32'h22});

    // requests while busy are ignored
    expect_res("mult_6x7_busy_starts", {32'd0, 32'd42});
    issue(EXE_MULT_OP, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    issue(EXE_MTHI_OP, 32'hDEAD, 32'h0);
    issue(EXE_DIVU_OP, 32'd9, 32'd3);
    chk("busy_mthi_ignored", {32'd0, hi}, 64'h11);
    wait_done("mult_6x7_busy_starts", -1);
    @(negedge clk);
    repeat (40) @(negedge clk);

    // asynchronous reset in the middle of a DIV
    issue(EXE_DIV_OP, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("reset_mid_div_busy", {63'd0, busy}, 64'd0);
    chk("reset_mid_div_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Multi-cycle multiply/divide engine for the MIPS execute stage. It owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not implement.
- Services MTHI and MTLO writes.
- Exposes HI/LO combinationally so the datapath can implement MFHI and MFLO.
- While busy=1, the hazard unit stalls the pipeline.

Parameters:
DW, 32, operand/HI/LO width; only 32 is supported.

Ports:
clk  input  1  clock; all state changes on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  operation request, sampled on rising edge
alucontrol  input  8  EXE_*_OP code from defines2.vh
a  input  32  rs operand (dividend, multiplicand, or MTHI/MTLO data)
b  input  32  rt operand (divisor, multiplier)
annul  input  1  flush; aborts an in-flight op
busy  output  1  engine occupied, request stall
done  output  1  one-cycle pulse; HI/LO hold the new result
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
Reset (resetn=0, asynchronous, any state):
- state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- An in-flight op is discarded.

FSM states: IDLE, MUL, DIV, FIN.

Request acceptance (at edge E0, only in IDLE with start=1 and annul=0):
- EXE_MULT_OP / EXE_MULTU_OP -> MUL.
- EXE_DIV_OP / EXE_DIVU_OP with b!=0 -> DIV.
- EXE_DIV_OP / EXE_DIVU_OP with b==0 -> FIN directly. HI/LO are not written; done pulses in the cycle after E1.
- EXE_MTHI_OP -> hi<=a at E0. EXE_MTLO_OP -> lo<=a at E0. State stays IDLE, no done pulse.
- Any other code -> ignored. This includes MFHI/MFLO, which are pure reads of hi/lo.
- start while not IDLE is ignored.

Operand capture at E0:
- Signed ops (MULT, DIV) store the magnitudes of a and b plus the result-sign flags:
  - product sign = a[31]^b[31]
  - quotient sign = a[31]^b[31]
  - remainder sign = a[31]
- Unsigned ops store the raw operands with both sign flags cleared.

Iteration (edges E1..E32, one bit per edge, 5-bit counter):
- MUL: radix-2 shift-add into a 64-bit accumulator.
- DIV: restoring shift-subtract producing a 32-bit quotient and remainder.
- After E32, state=FIN.

FIN (edge E33):
- Apply two's-complement negation per the sign flags.
- Write {hi,lo} (MUL: hi=product[63:32], lo=product[31:0]; DIV: lo=quotient, hi=remainder).
- state -> IDLE.
- done=1 for exactly the cycle after E33. The new hi/lo are visible in that same cycle.

Timing and handshake:
- busy=1 from the cycle after E0 through the cycle ending at E33. The zero-divisor path holds busy=1 for one cycle.
- busy is registered.
- busy and done are never both 1.
- A new start is accepted in the done cycle; back-to-back ops are allowed.

Arithmetic rules:
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0. No trap.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.

Annul:
- annul=1 in MUL, DIV or FIN aborts the op: state->IDLE at the next edge, hi/lo unchanged, no done pulse.
- annul=1 together with start in IDLE suppresses the request, including MTHI/MTLO.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> busy for 33 cycles, then done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Follow it immediately with DIVU a=100, b=7 started in the done cycle -> lo=14, hi=2.
- DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- With hi=0x11, lo=0x22 preset via MTHI/MTLO (each visible the cycle after its edge, no done pulse): DIVU b=0 -> done one cycle later, hi=0x11, lo=0x22 unchanged.
- MULT started, annul=1 at iteration 10 -> IDLE next cycle, no done, hi/lo unchanged. Drive resetn low mid-DIV -> busy=0, hi=lo=0 immediately.
- start with EXE_MFHI_OP or EXE_ADD_OP -> no state change, busy stays 0. start during busy -> ignored; the first result is unaffected.
